// File: rtl/tt_um_micro_tdc_coarse.sv
// Coarse TDC micro-tile: counts clock cycles between synchronized start and stop
// rises, saturating at all-ones, with a byte-wise readout of result, status and tally.
`timescale 1ns/1ps
module tt_um_micro_tdc_coarse #(
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUNNING,
    S_DONE
  } state_e;

  localparam int unsigned SW = SYNC_STAGES * 3;

  state_e               state_q, state_d;
  logic [SW-1:0]        sync_q, sync_d;
  logic [2:0]           edge_q, edge_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           tally_q, tally_d;

  logic [2:0]  sync_out;
  logic [2:0]  rise;
  logic        start_rise, stop_rise, arm_rise;
  logic [15:0] count16;
  logic        unused_inputs;

  assign unused_inputs = ^ui_in[7:5];

  // Each stage holds {arm, stop, start}; newest sample enters at the bottom.
  assign sync_d     = {sync_q[SW-4:0], ui_in[2:0]};
  assign sync_out   = sync_q[SW-1 -: 3];
  assign edge_d     = sync_out;
  assign rise       = sync_out & ~edge_q;
  assign start_rise = rise[0];
  assign stop_rise  = rise[1];
  assign arm_rise   = rise[2];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    tally_d = tally_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_rise) begin
          state_d = S_ARMED;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (start_rise) begin
          state_d = S_RUNNING;
          count_d = '0;
        end
      end
      S_RUNNING: begin
        // The stop cycle itself is counted so that the result equals the edge distance.
        if (count_q == '1) begin
          state_d = S_DONE;
          ovf_d   = 1'b1;
          tally_d = tally_q + 8'd1;
        end else begin
          count_d = count_q + 1'b1;
          if (stop_rise) begin
            state_d = S_DONE;
            tally_d = tally_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      edge_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      tally_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      tally_q <= tally_d;
    end
  end

  assign count16 = 16'(count_q);

  always_comb begin
    uo_out = '0;
    case (ui_in[4:3])
      2'b00: uo_out = {tally_q[3:0], ovf_q, state_q == S_DONE,
                       state_q == S_RUNNING, state_q == S_ARMED};
      2'b01: uo_out = count16[7:0];
      2'b10: uo_out = count16[15:8];
      default: uo_out = tally_q;
    endcase
  end

endmodule

// File: tb/tb_tt_um_micro_tdc_coarse.sv
// Bench for the coarse TDC tile: timestamp-based reference model checked every
// cycle, plus directed measurements with literal expected readouts.
`timescale 1ns/1ps
module tb_tt_um_micro_tdc_coarse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, arm = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  assign ui_in = {3'b000, sel, arm, stop, start};

  always #5 clk = ~clk;

  tt_um_micro_tdc_coarse #(.COUNT_W(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ui_in (ui_in),
    .uo_out(uo_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 running, 3 done.
  // Running count is the number of edges since the start took effect.
  int         m_mode;
  longint     now, t_start;
  int         m_cnt;
  logic       m_ovf;
  logic [7:0] m_tally;
  logic [2:0] s_prev, d1, d2, r, ap;

  function automatic logic [7:0] m_byte(input logic [1:0] s);
    logic [15:0] c;
    c = m_cnt[15:0];
    case (s)
      2'd0: return {m_tally[3:0], m_ovf, m_mode == 3, m_mode == 2, m_mode == 1};
      2'd1: return c[7:0];
      2'd2: return c[15:8];
      default: return m_tally;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; now = 0; t_start = 0; m_cnt = 0; m_ovf = 1'b0; m_tally = 8'd0;
      s_prev = 3'b000; d1 = 3'b000; d2 = 3'b000;
    end else begin
      r = ui_in[2:0] & ~s_prev;
      s_prev = ui_in[2:0];
      ap = d2; d2 = d1; d1 = r;
      now++;
      if ((m_mode == 0 || m_mode == 3) && ap[2]) begin
        m_mode = 1; m_cnt = 0; m_ovf = 1'b0;
      end else if (m_mode == 1 && ap[0]) begin
        m_mode = 2; m_cnt = 0; t_start = now;
      end else if (m_mode == 2) begin
        if (now - t_start > 65535) begin
          m_mode = 3; m_cnt = 65535; m_ovf = 1'b1; m_tally = m_tally + 8'd1;
        end else begin
          m_cnt = int'(now - t_start);
          if (ap[1]) begin
            m_mode = 3; m_tally = m_tally + 8'd1;
          end
        end
      end
      #1;
      if (rst_n) check("cycle_model", uo_out, m_byte(sel));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] s, output logic [7:0] v);
    sel = s;
    #1;
    v = uo_out;
  endtask

  task automatic pulse_arm();
    @(negedge clk) arm = 1'b1;
    wait_neg(2);
    arm = 1'b0;
    wait_neg(3);
  endtask

  task automatic measure(input int n);
    pulse_arm();
    start = 1'b1;
    wait_neg(n);
    stop = 1'b1;
    wait_neg(4);
    start = 1'b0;
    stop = 1'b0;
    wait_neg(2);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
  endtask

  logic [7:0] v;

  initial begin
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(1);
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v); check("reset_byte", v, 8'h00);
    end

    pulse_arm();
    rd(2'd0, v); check("armed_status", v, 8'h01);
    start = 1'b1;
    wait_neg(100);
    stop = 1'b1;
    wait_neg(4);
    start = 1'b0; stop = 1'b0;
    wait_neg(2);
    rd(2'd0, v); check("n100_status", v, 8'h14);
    rd(2'd1, v); check("n100_lo", v, 8'h64);
    rd(2'd2, v); check("n100_hi", v, 8'h00);
    rd(2'd3, v); check("n100_tally", v, 8'h01);
    check("model_n100", m_cnt, 100);

    // Start and stop together: stop ignored, second stop 5 cycles after start
    pulse_arm();
    rd(2'd0, v); check("rearm_status", v, 8'h11);
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    wait_neg(2);
    stop = 1'b0;
    wait_neg(2);
    rd(2'd0, v); check("same_edge_running", v, 8'h12);
    wait_neg(1);
    stop = 1'b1;
    wait_neg(4);
    start = 1'b0; stop = 1'b0;
    wait_neg(2);
    rd(2'd1, v); check("n5_lo", v, 8'h05);
    rd(2'd2, v); check("n5_hi", v, 8'h00);
    rd(2'd0, v); check("n5_status", v, 8'h24);

    pulse_arm();
    stop = 1'b1;
    wait_neg(5);
    stop = 1'b0;
    wait_neg(2);
    rd(2'd0, v); check("stop_while_armed", v, 8'h21);

    // Overflow: no stop for more than 65535 cycles
    start = 1'b1;
    wait_neg(65545);
    rd(2'd0, v); check("ovf_status", v, 8'h3C);
    rd(2'd1, v); check("ovf_lo", v, 8'hFF);
    rd(2'd2, v); check("ovf_hi", v, 8'hFF);
    check("model_ovf", m_cnt, 65535);
    start = 1'b0;
    wait_neg(2);
    stop = 1'b1;
    wait_neg(6);
    stop = 1'b0;
    rd(2'd0, v); check("ovf_late_stop_status", v, 8'h3C);
    rd(2'd1, v); check("ovf_late_stop_lo", v, 8'hFF);

    // Reset mid-measurement
    pulse_arm();
    start = 1'b1;
    wait_neg(20);
    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v); check("midrun_reset_byte", v, 8'h00);
    end
    start = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
    measure(7);
    rd(2'd1, v); check("n7_lo", v, 8'h07);
    rd(2'd3, v); check("n7_tally", v, 8'h01);
    rd(2'd0, v); check("n7_status", v, 8'h14);

    // Tally wrap after 256 measurements
    do_reset();
    for (int i = 0; i < 256; i++) measure(3);
    rd(2'd3, v); check("tally_wrap", v, 8'h00);
    rd(2'd1, v); check("n3_lo", v, 8'h03);
    rd(2'd0, v); check("wrap_status", v, 8'h04);
    start = 1'b1;
    wait_neg(6);
    start = 1'b0;
    wait_neg(1);
    rd(2'd1, v); check("start_in_done_lo", v, 8'h03);
    rd(2'd0, v); check("start_in_done_status", v, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
